// File: rtl/alu_div.sv
// Radix-2 restoring divider, one quotient bit per clock, signed or unsigned.
// Results are registered and presented with a one-cycle done pulse.
module alu_div #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dvs_mag;
    logic             dvd_neg;
    logic             q_neg;
    logic             dz_r;

    logic             dvd_sign_in;
    logic             dvs_sign_in;
    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             sub_ok;

    assign dvd_sign_in = is_signed & dividend[WIDTH-1];
    assign dvs_sign_in = is_signed & divisor[WIDTH-1];
    assign dvd_mag_in  = dvd_sign_in ? (~dividend + 1'b1) : dividend;
    assign dvs_mag_in  = dvs_sign_in ? (~divisor + 1'b1) : divisor;

    // quo_r starts as the dividend magnitude: its MSB feeds the partial
    // remainder while quotient bits fill in from the bottom.
    assign shifted = {rem_r, quo_r[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_mag};
    // A set top bit means shifted exceeds any WIDTH-bit divisor; otherwise
    // the top bit of the difference is the borrow.
    assign sub_ok  = shifted[WIDTH] | ~diff[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            cnt         <= '0;
            rem_r       <= '0;
            quo_r       <= '0;
            dvs_mag     <= '0;
            dvd_neg     <= 1'b0;
            q_neg       <= 1'b0;
            dz_r        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state   <= CALC;
                        busy    <= 1'b1;
                        cnt     <= CW'(WIDTH - 1);
                        rem_r   <= '0;
                        quo_r   <= dvd_mag_in;
                        dvs_mag <= dvs_mag_in;
                        dvd_neg <= dvd_sign_in;
                        q_neg   <= dvd_sign_in ^ dvs_sign_in;
                        dz_r    <= (divisor == '0);
                    end
                end
                CALC: begin
                    if (sub_ok) begin
                        rem_r <= diff[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_r <= shifted[WIDTH-1:0];
                        quo_r <= {quo_r[WIDTH-2:0], 1'b0};
                    end
                    if (cnt == '0) begin
                        state <= FIX;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                FIX: begin
                    // With a zero divisor every trial succeeds, so the remainder
                    // is the dividend magnitude and re-signing restores the dividend.
                    quotient    <= dz_r ? '1 : (q_neg ? (~quo_r + 1'b1) : quo_r);
                    remainder   <= dvd_neg ? (~rem_r + 1'b1) : rem_r;
                    div_by_zero <= dz_r;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_div.sv
// Bench for alu_div: directed corner cases, restart/abort scenarios and random
// operands scored against an arithmetic reference model.
module tb_alu_div;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    alu_div #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // clock / reset block
    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // scoreboard
    int             n_checks = 0;
    int             n_bad    = 0;
    logic [2*W:0]   exp_q[$];
    logic [W-1:0]   hold_q  = '0;
    logic [W-1:0]   hold_r  = '0;
    logic           hold_dz = 1'b0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: {div_by_zero, quotient, remainder} from plain 64-bit arithmetic.
    function automatic logic [2*W:0] ref_div(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        longint       na;
        longint       nb;
        longint       nq;
        longint       nr;
        logic [W-1:0] q;
        logic [W-1:0] r;
        if (b == '0) return {1'b1, {W{1'b1}}, a};
        na = s ? longint'($signed(a)) : longint'(a);
        nb = s ? longint'($signed(b)) : longint'(b);
        nq = na / nb;
        nr = na % nb;
        q  = nq[W-1:0];
        r  = nr[W-1:0];
        return {1'b0, q, r};
    endfunction

    // driver: one full operation; repulse pokes start in cycle 5 and the done cycle
    task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b, input bit repulse);
        int           t0;
        int           c;
        int           tdone;
        bit           busy_ok;
        bit           hold_ok;
        bit           seen;
        logic [2*W:0] e;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        seen    = 1'b0;
        tdone   = -1;
        @(negedge clk);
        check_eq("idle_at_launch", busy, 1'b0);
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        t0        = cyc_cnt;
        exp_q.push_back(ref_div(s, a, b));
        for (int k = 0; k < W + 8 && !seen; k++) begin
            @(negedge clk);
            c = cyc_cnt - t0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                seen  = 1'b1;
                tdone = c;
            end else if ({quotient, remainder, div_by_zero} !== {hold_q, hold_r, hold_dz}) begin
                hold_ok = 1'b0;
            end
            start     = 1'b0;
            is_signed = 1'($urandom_range(0, 1));
            dividend  = $urandom;
            divisor   = $urandom;
            if (repulse && (c == 5 || c == W + 2)) start = 1'b1;
        end
        check_eq("busy_window", busy_ok, 1'b1);
        check_eq("outputs_held", hold_ok, 1'b1);
        check_eq("done_seen", seen, 1'b1);
        e = exp_q.pop_front();
        if (seen) begin
            check_eq("latency", tdone, W + 2);
            check_eq("quotient", quotient, e[2*W-1:W]);
            check_eq("remainder", remainder, e[W-1:0]);
            check_eq("div_by_zero", div_by_zero, e[2*W]);
        end
        hold_q  = e[2*W-1:W];
        hold_r  = e[W-1:0];
        hold_dz = e[2*W];
        if (!repulse) begin
            @(negedge clk);
            check_eq("idle_after_done", {busy, done}, 2'b00);
        end
    endtask

    initial begin
        int   t0;
        bit   no_done;
        logic s;
        logic [W-1:0] a;
        logic [W-1:0] b;

        // reset with start held high: must be ignored
        rst       = 1'b1;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_state", {busy, done, quotient, remainder, div_by_zero}, '0);
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_eq("idle_after_reset", {busy, done}, 2'b00);

        // directed corner cases
        run_op(1'b0, 32'd100, 32'd7, 1'b0);
        run_op(1'b1, -32'sd7, 32'd2, 1'b0);
        run_op(1'b1, 32'd7, -32'sd2, 1'b0);
        run_op(1'b0, 32'h1234_5678, 32'd0, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b1, 32'hFFFF_FF00, 32'd0, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b0, 32'h8000_0000, 32'h8000_0001, 1'b0);

        // start re-pulsed while busy and in the done cycle, then back-to-back
        run_op(1'b0, 32'd1000, 32'd10, 1'b1);
        run_op(1'b0, 32'd55, 32'd5, 1'b0);

        // asynchronous reset in cycle 20 aborts the operation
        @(negedge clk);
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        t0        = cyc_cnt;
        @(negedge clk);
        start = 1'b0;
        while (cyc_cnt - t0 < 20) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_eq("reset_async", {busy, done, quotient, remainder, div_by_zero}, '0);
        start = 1'b1;
        @(posedge clk);
        #1;
        check_eq("reset_held", {busy, done, quotient, remainder, div_by_zero}, '0);
        @(negedge clk);
        rst     = 1'b0;
        start   = 1'b0;
        hold_q  = '0;
        hold_r  = '0;
        hold_dz = 1'b0;
        no_done = 1'b1;
        repeat (W + 6) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check_eq("no_done_after_abort", no_done, 1'b1);
        run_op(1'b0, 32'd9, 32'd3, 1'b0);

        // random operands
        repeat (40) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = 32'($urandom_range(1, 15));
                2: begin
                    a = 32'h8000_0000;
                    b = 32'hFFFF_FFFF;
                end
                3:       a = 32'($urandom_range(0, 255));
                default: b = $urandom;
            endcase
            run_op(s, a, b, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_div.md
ALU_DIV -- requirements
Module: alu_div

Interface
REQ-001 The module SHALL have parameter WIDTH, default 32, meaning operand and result width in bits.
REQ-002 The module SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 The module SHALL have port start  input  1  request pulse; sampled only in IDLE.
REQ-005 The module SHALL have port is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 The module SHALL have port dividend  input  WIDTH  numerator; sampled with start.
REQ-007 The module SHALL have port divisor  input  WIDTH  denominator; sampled with start.
REQ-008 The module SHALL have port busy  output  1  high in every state except IDLE.
REQ-009 The module SHALL have port done  output  1  one-cycle pulse marking valid results.
REQ-010 The module SHALL have port quotient  output  WIDTH  registered quotient.
REQ-011 The module SHALL have port remainder  output  WIDTH  registered remainder.
REQ-012 The module SHALL have port div_by_zero  output  1  registered flag, valid with done.

Function
REQ-013 The module SHALL implement a radix-2 restoring divider on operand magnitudes, one quotient bit per clock.
REQ-014 The state machine SHALL have states IDLE, CALC, FIX, DONE.
REQ-015 IDLE -> CALC when start=1 at a rising edge; operands, is_signed latched; magnitudes formed (negate if is_signed and MSB=1); iteration counter loaded with WIDTH-1.
REQ-016 In CALC, each cycle SHALL shift partial remainder left by one bit, bringing in the next dividend bit MSB-first, trial-subtract divisor magnitude with a WIDTH+1-bit subtraction, keep the difference and shift in quotient bit 1 when non-negative, else restore and shift in 0.
REQ-017 CALC -> FIX after exactly WIDTH iterations (counter reaching 0); counter SHALL not wrap.
REQ-018 In FIX, signed mode: quotient negated when dividend and divisor signs differ; remainder negated when dividend negative; results written to quotient/remainder/div_by_zero registers; FIX -> DONE.
REQ-019 In DONE, done=1 for exactly one cycle; DONE -> IDLE unconditionally.
REQ-020 Latency: start high in cycle 0 -> CALC cycles 1..WIDTH, FIX cycle WIDTH+1, done=1 in cycle WIDTH+2 (34 for WIDTH=32); latency fixed, independent of operand values.
REQ-021 start while busy=1 SHALL be ignored, with no effect on the operation in flight.
REQ-022 start in DONE cycle SHALL be ignored; a new start is accepted from IDLE, giving back-to-back throughput of one result per WIDTH+3 cycles.
REQ-023 quotient, remainder, div_by_zero SHALL hold their last values from the DONE cycle until the next FIX write; never change in CALC.
REQ-024 Divisor=0 (either mode): quotient all ones, remainder = original dividend unmodified, div_by_zero=1, same latency as normal operation.
REQ-025 Signed overflow (dividend = most negative, divisor = -1): quotient = most negative value (wraps), remainder = 0, div_by_zero=0.
REQ-026 Signed results SHALL truncate toward zero; remainder sign equals dividend sign, |remainder| < |divisor|.
REQ-027 Unsigned mode: operands used unmodified; no negation in FIX.

Reset
REQ-028 rst=1 SHALL immediately, without waiting for clk, force state IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, counter=0.
REQ-029 rst asserted mid-operation SHALL abort it; no done pulse for the aborted operation; first start after rst deasserts proceeds normally.
REQ-030 start high during rst SHALL be ignored.

Verification
REQ-031 Unsigned 100 / 7, start in cycle 0 -> busy cycles 1..34, done=1 only in cycle 34, quotient=14, remainder=2, div_by_zero=0.
REQ-032 Signed -7 / 2 -> quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); signed 7 / -2 -> quotient=-3, remainder=1.
REQ-033 Divide by zero: unsigned 0x12345678 / 0 -> quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1, done in cycle 34.
REQ-034 Signed 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-035 start re-pulsed in cycles 5 and 34 of an operation -> both ignored, single done, results of first operation; start in cycle 35 accepted, next done in cycle 69.
REQ-036 rst pulsed asynchronously in cycle 20 of an operation -> outputs zero immediately, no done; subsequent 9 / 3 unsigned -> quotient=3, remainder=0 after 34 cycles.
